// File: rtl/gate_div_gen.sv
// Gate-domain reference divider: emits a HIGH_CYCLES-wide gate pulse every DIV_GATE cycles,
// with whole-period +/- DIV_GATE_INCDEC_DELTA trim chosen only at period boundaries.
module gate_div_gen #(
  parameter int unsigned DIV_GATE              = 2000000,
  parameter int unsigned DIV_GATE_INCDEC_DELTA = DIV_GATE / 2000,
  parameter int unsigned HIGH_CYCLES           = 16,
  parameter int unsigned PCNT_WIDTH            = 16,
  parameter int unsigned FF_SYNC_DEPTH         = 2
) (
  input  logic                  i_clk_gate,
  input  logic                  rst_gate,
  input  logic                  i_ctl_en,
  input  logic                  i_ctl_gate_fdec,
  input  logic                  i_ctl_gate_finc,
  output logic                  o_gate,
  output logic                  o_period_start,
  output logic [1:0]            o_trim,
  output logic [PCNT_WIDTH-1:0] o_period_cnt
);

  localparam int unsigned CntW  = $clog2(DIV_GATE + DIV_GATE_INCDEC_DELTA);
  localparam int unsigned HcntW = (HIGH_CYCLES > 1) ? $clog2(HIGH_CYCLES) : 1;

  localparam logic [CntW-1:0]  NNom  = CntW'(DIV_GATE - 1);
  localparam logic [CntW-1:0]  NDec  = CntW'(DIV_GATE + DIV_GATE_INCDEC_DELTA - 1);
  localparam logic [CntW-1:0]  NInc  = CntW'(DIV_GATE - DIV_GATE_INCDEC_DELTA - 1);
  localparam logic [HcntW-1:0] HLoad = HcntW'(HIGH_CYCLES - 1);

  // Bit order per stage: {finc, fdec, en}.
  logic [2:0] sync_q [FF_SYNC_DEPTH];
  logic [2:0] ctl_s;
  logic       en_s, fdec_s, finc_s;

  always_ff @(posedge i_clk_gate or posedge rst_gate) begin
    if (rst_gate) begin
      for (int i = 0; i < FF_SYNC_DEPTH; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {i_ctl_gate_finc, i_ctl_gate_fdec, i_ctl_en};
      for (int i = 1; i < FF_SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ctl_s  = sync_q[FF_SYNC_DEPTH-1];
  assign en_s   = ctl_s[0];
  assign fdec_s = ctl_s[1];
  assign finc_s = ctl_s[2];

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [HcntW-1:0]      hcnt_q, hcnt_d;
  logic                  gate_q, gate_d;
  logic                  start_q, start_d;
  logic [1:0]            trim_q, trim_d;
  logic [PCNT_WIDTH-1:0] pcnt_q, pcnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    gate_d  = gate_q;
    start_d = 1'b0;
    trim_d  = trim_q;
    pcnt_d  = pcnt_q;
    if (!en_s) begin
      // Clearing cnt makes the first enabled cycle a boundary.
      cnt_d  = '0;
      hcnt_d = '0;
      gate_d = 1'b0;
    end else if (cnt_q == '0) begin
      case ({finc_s, fdec_s})
        2'b01: begin
          cnt_d  = NDec;
          trim_d = 2'b01;
        end
        2'b10: begin
          cnt_d  = NInc;
          trim_d = 2'b10;
        end
        default: begin
          cnt_d  = NNom;
          trim_d = 2'b00;
        end
      endcase
      hcnt_d  = HLoad;
      gate_d  = 1'b1;
      start_d = 1'b1;
      pcnt_d  = pcnt_q + PCNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q - CntW'(1);
      if (hcnt_q == '0) begin
        gate_d = 1'b0;
      end else begin
        hcnt_d = hcnt_q - HcntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk_gate or posedge rst_gate) begin
    if (rst_gate) begin
      cnt_q   <= '0;
      hcnt_q  <= '0;
      gate_q  <= 1'b0;
      start_q <= 1'b0;
      trim_q  <= 2'b00;
      pcnt_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      gate_q  <= gate_d;
      start_q <= start_d;
      trim_q  <= trim_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign o_gate         = gate_q;
  assign o_period_start = start_q;
  assign o_trim         = trim_q;
  assign o_period_cnt   = pcnt_q;

endmodule

// File: doc/gate_div_gen.md
# gate_div_gen

Gate-domain reference divider with whole-period frequency trim. It divides `i_clk_gate` into a gate pulse train with nominal period `DIV_GATE` cycles, or `DIV_GATE ± DIV_GATE_INCDEC_DELTA` when trim is requested. The trim is applied only at period boundaries, so no period is ever truncated. It sits directly upstream of the TDC pipeline's gate input. The stretched high time lets the TDC-domain synchronizer capture every pulse.

## Interface

Parameters:
- `DIV_GATE`, default 2000000: nominal period in `i_clk_gate` cycles.
- `DIV_GATE_INCDEC_DELTA`, default `DIV_GATE/2000`: period adjustment in cycles.
- `HIGH_CYCLES`, default 16: `o_gate` high time in cycles; must satisfy 1 ≤ `HIGH_CYCLES` < `DIV_GATE - DIV_GATE_INCDEC_DELTA`.
- `PCNT_WIDTH`, default 16: width of the period counter.
- `FF_SYNC_DEPTH`, default 2: synchronizer depth for the asynchronous control inputs.

Ports:
- `i_clk_gate`  in  1  gate clock.
- `rst_gate`  in  1  reset, asynchronous, active-high; clock `i_clk_gate`.
- `i_ctl_en`  in  1  async; enables the divider.
- `i_ctl_gate_fdec`  in  1  async; requests a lengthened period (lower frequency).
- `i_ctl_gate_finc`  in  1  async; requests a shortened period (higher frequency).
- `o_gate`  out  1  divided gate output, registered.
- `o_period_start`  out  1  one-cycle strobe coincident with the rising edge of `o_gate`.
- `o_trim`  out  2  trim applied to the current period: 00 nominal, 01 fdec, 10 finc; 11 never occurs.
- `o_period_cnt`  out  `PCNT_WIDTH`  number of started periods, wraps modulo 2^`PCNT_WIDTH`.

## Operation

Input synchronization:
- All three control inputs pass through `FF_SYNC_DEPTH`-stage synchronizers, reset to 0. The outputs are `en_s`, `fdec_s`, `finc_s`.

Internal state:
- `cnt`: period down-counter, width `$clog2(DIV_GATE + DIV_GATE_INCDEC_DELTA)`.
- `hcnt`: high-time down-counter.

Boundary condition: `en_s = 1` and `cnt == 0`. On a boundary cycle:
- Trim selection:
  - `fdec_s` only: N = `DIV_GATE + DELTA`, `o_trim` ← 01.
  - `finc_s` only: N = `DIV_GATE - DELTA`, `o_trim` ← 10.
  - Neither, or both (conflict resolves to nominal): N = `DIV_GATE`, `o_trim` ← 00.
- `cnt` ← N-1.
- `hcnt` ← `HIGH_CYCLES-1`.
- `o_gate` ← 1, `o_period_start` ← 1.
- `o_period_cnt` ← `o_period_cnt + 1`, wrapping.

Other enabled cycles:
- `cnt` ← `cnt - 1`.
- `o_period_start` ← 0.
- If `hcnt == 0`: `o_gate` ← 0. Otherwise `hcnt` ← `hcnt - 1`.

Disabled (`en_s = 0`):
- `cnt` ← 0, `hcnt` ← 0.
- `o_gate` ← 0, `o_period_start` ← 0.
- `o_trim` and `o_period_cnt` hold.

Two states are implied: IDLE (`en_s = 0`) and RUN (`en_s = 1`).
- IDLE → RUN: the first enabled cycle is always a boundary, because `cnt` = 0.
- RUN → IDLE: at the next edge after `en_s` falls. This applies at any point, including during the high time.

Trim changes mid-period never alter the period in progress. The period length is latched at the boundary.

## Timing

Reset values (asynchronous):
- `cnt` = 0, `hcnt` = 0.
- `o_gate` = 0, `o_period_start` = 0, `o_trim` = 00, `o_period_cnt` = 0.
- Synchronizer stages = 0.

Period and pulse timing:
- Spacing between consecutive `o_period_start` strobes is exactly N cycles, with N selected at the earlier strobe.
- `o_gate` is high for exactly `HIGH_CYCLES` cycles, starting in the strobe cycle.

Control latency:
- A change on `i_ctl_*` is visible internally after `FF_SYNC_DEPTH` edges.
- A trim change takes effect at the first boundary after that.
- First strobe after `i_ctl_en` rises: `FF_SYNC_DEPTH + 1` edges.

Reset mid-operation: all outputs return to their reset values immediately. Operation resumes as on the first enable.

## Test plan

All scenarios use `DIV_GATE=20`, `DELTA=4`, `HIGH_CYCLES=3`, `PCNT_WIDTH=4`, `FF_SYNC_DEPTH=2`.

1. Release reset, hold `i_ctl_en=1`, trims 0 → first strobe 3 edges after the enable rise; strobes every 20 cycles; `o_gate` high for 3 cycles; `o_period_cnt` = 1, 2, 3…; `o_trim` = 00.
2. Hold `i_ctl_gate_fdec=1` → the next boundary gives period 24 with `o_trim=01`. Hold `finc=1` → period 16 with `o_trim=10`. Assert both → period 20 with `o_trim=00`.
3. Pulse `finc` high for 5 cycles mid-period, deasserting before the boundary → the current and following periods stay at 20. No strobe timing change.
4. Drop `i_ctl_en` while `o_gate` is high → `o_gate` is low 3 edges later and strobes stop; `o_period_cnt` and `o_trim` hold. Re-enable → strobe after 3 edges; count resumes from its held value.
5. Run 17 periods → `o_period_cnt` goes 15 → 0 → 1.
6. Assert `rst_gate` for 1 cycle mid-high-time → all outputs are 0 immediately; with enable held, the first strobe comes 3 edges after release and `o_period_cnt` = 1.
